// File: rtl/pdecode_acc_if.sv
// Handshake bundle between a code producer/frame consumer and pdecode_acc.
// The master side drives codes and A_ready; the slave (decoder) returns the rebuilt frame.
interface pdecode_acc_if #(
    parameter int W = 3
);
    localparam int N = 1 << W;

    logic [W-1:0] Y;
    logic         Valid;
    logic         Last;
    logic         in_ready;
    logic [N-1:0] A;
    logic         A_valid;
    logic         A_ready;
    logic [W:0]   Count;
    logic         Dup;

    modport master (
        output Y, Valid, Last, A_ready,
        input  in_ready, A, A_valid, Count, Dup
    );

    modport slave (
        input  Y, Valid, Last, A_ready,
        output in_ready, A, A_valid, Count, Dup
    );
endinterface

// File: rtl/pdecode_acc.sv
// Sequential 3-to-8 decoder/accumulator: ORs one-hot decoded codes into a frame
// vector, counts distinct bits, flags duplicates and presents the frame on valid/ready.
module pdecode_acc #(
    parameter int W = 3
) (
    input  logic          clk,
    input  logic          reset,
    pdecode_acc_if.slave  bus
);
    localparam int N = 1 << W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [W:0]   count_q, count_d;
    logic         dup_q, dup_d;

    logic [N-1:0] onehot;
    logic         in_ready;
    logic         accept;
    logic         close;
    logic         hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dec
            assign onehot[gi] = (bus.Y == W'(gi));
        end
    endgenerate

    assign in_ready = (state_q != PRESENT);
    assign accept   = bus.Valid & in_ready;
    assign close    = bus.Last & in_ready;
    assign hit      = |(a_q & onehot);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        count_d = count_q;
        dup_d   = dup_q;

        if (state_q == PRESENT) begin
            // Frame leaves on the handshake edge and the accumulator starts empty.
            if (bus.A_ready) begin
                state_d = IDLE;
                a_d     = '0;
                count_d = '0;
                dup_d   = 1'b0;
            end
        end else begin
            if (accept) begin
                if (hit) begin
                    dup_d = 1'b1;
                end else begin
                    a_d     = a_q | onehot;
                    count_d = count_q + {{W{1'b0}}, 1'b1};
                end
            end
            if (close) begin
                state_d = PRESENT;
            end else if (accept) begin
                state_d = COLLECT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            count_q <= count_d;
            dup_q   <= dup_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.A        = a_q;
    assign bus.A_valid  = (state_q == PRESENT);
    assign bus.Count    = count_q;
    assign bus.Dup      = dup_q;
endmodule

// File: tb/tb_pdecode_acc.sv
// Directed bench for pdecode_acc: expected frames go into a queue at close time and a
// monitor pops them on every A_valid && A_ready transfer; direct checks cover timing.
module tb_pdecode_acc;
    logic clk;
    logic reset;

    pdecode_acc_if #(.W(3)) bus();

    pdecode_acc #(.W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [3:0] cnt;
        logic       dup;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   frames_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: a transfer happens at the edge following this sample point.
    always @(negedge clk) begin
        if (!reset && bus.A_valid === 1'b1 && bus.A_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got A=0x%0h with no frame expected", bus.A);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                frames_seen++;
                chk("frame_A", 32'(bus.A), 32'(e.a));
                chk("frame_Count", 32'(bus.Count), 32'(e.cnt));
                chk("frame_Dup", 32'(bus.Dup), 32'(e.dup));
                $display("frame %0d: A=0x%02h Count=%0d Dup=%0d", frames_seen, bus.A, bus.Count, bus.Dup);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] y, input logic v, input logic l);
        bus.Y     = y;
        bus.Valid = v;
        bus.Last  = l;
    endtask

    task automatic expect_frame(input logic [7:0] a, input logic [3:0] c, input logic d);
        exp_t e;
        e.a = a; e.cnt = c; e.dup = d;
        exp_q.push_back(e);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_A"}, 32'(bus.A), 32'h0);
        chk({tag, "_Count"}, 32'(bus.Count), 32'h0);
        chk({tag, "_Dup"}, 32'(bus.Dup), 32'h0);
        chk({tag, "_A_valid"}, 32'(bus.A_valid), 32'h0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'h1);
    endtask

    // Encoder model used only to produce loopback stimulus.
    function automatic logic [2:0] enc_hi(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    logic [7:0] lb_vec [6] = '{8'b01010100, 8'h01, 8'h80, 8'h00, 8'b00111000, 8'hFF};
    logic [7:0] lb_exp [6] = '{8'b01000000, 8'h01, 8'h80, 8'h00, 8'b00100000, 8'h80};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(3'd0, 1'b0, 1'b0);
        bus.A_ready = 1'b0;
        cyc(); cyc();
        chk_cleared("reset");
        reset = 1'b0;

        // Frame 1: codes 0,1,2, Last with the third
        drive(3'd0, 1'b1, 1'b0); cyc();
        chk("acc1_A", 32'(bus.A), 32'h01);
        chk("acc1_Count", 32'(bus.Count), 32'd1);
        chk("acc1_A_valid", 32'(bus.A_valid), 32'h0);
        drive(3'd1, 1'b1, 1'b0); cyc();
        drive(3'd2, 1'b1, 1'b1); expect_frame(8'b00000111, 4'd3, 1'b0); cyc();
        chk("close1_A_valid", 32'(bus.A_valid), 32'h1);
        chk("close1_in_ready", 32'(bus.in_ready), 32'h0);
        drive(3'd0, 1'b0, 1'b0);
        bus.A_ready = 1'b1; cyc();
        bus.A_ready = 1'b0;
        chk_cleared("xfer1");

        // Frame 2: duplicate code 3, Last alone
        drive(3'd3, 1'b1, 1'b0); cyc();
        drive(3'd5, 1'b1, 1'b0); cyc();
        drive(3'd3, 1'b1, 1'b0); cyc();
        chk("dup_Dup", 32'(bus.Dup), 32'h1);
        chk("dup_Count", 32'(bus.Count), 32'd2);
        chk("dup_A", 32'(bus.A), 32'h28);
        drive(3'd7, 1'b1, 1'b0); cyc();
        drive(3'd0, 1'b0, 1'b1); expect_frame(8'b10101000, 4'd3, 1'b1); cyc();
        chk("close2_A_valid", 32'(bus.A_valid), 32'h1);
        drive(3'd0, 1'b0, 1'b0);
        bus.A_ready = 1'b1; cyc();
        bus.A_ready = 1'b0;

        // Frame 3: empty frame, then PRESENT ignores inputs
        drive(3'd0, 1'b0, 1'b1); expect_frame(8'h00, 4'd0, 1'b0); cyc();
        for (int i = 0; i < 5; i++) begin
            drive(3'(i + 2), 1'b1, 1'b1); cyc();
            chk("hold_A_valid", 32'(bus.A_valid), 32'h1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'h0);
            chk("hold_A", 32'(bus.A), 32'h0);
            chk("hold_Count", 32'(bus.Count), 32'h0);
        end
        drive(3'd0, 1'b0, 1'b0);
        bus.A_ready = 1'b1; cyc();
        chk_cleared("xfer3");

        // Frame 4: all codes 7..0 back-to-back with A_ready held high
        for (int i = 7; i >= 0; i--) begin
            drive(3'(i), 1'b1, (i == 0));
            if (i == 0) expect_frame(8'hFF, 4'd8, 1'b0);
            cyc();
            chk("b2b_Count", 32'(bus.Count), 32'(8 - i));
        end
        chk("b2b_A_valid", 32'(bus.A_valid), 32'h1);
        drive(3'd0, 1'b0, 1'b0); cyc();
        chk("b2b_one_present", 32'(bus.A_valid), 32'h0);
        drive(3'd4, 1'b1, 1'b1); expect_frame(8'b00010000, 4'd1, 1'b0); cyc();
        chk("next_A", 32'(bus.A), 32'h10);
        drive(3'd0, 1'b0, 1'b0); cyc();
        bus.A_ready = 1'b0;

        // Reset during COLLECT, with a code and Last pending on the same edge
        drive(3'd0, 1'b1, 1'b0); cyc();
        drive(3'd1, 1'b1, 1'b0); cyc();
        drive(3'd4, 1'b1, 1'b0); cyc();
        chk("rst_col_A", 32'(bus.A), 32'h13);
        drive(3'd7, 1'b1, 1'b1);
        reset = 1'b1; cyc();
        reset = 1'b0;
        drive(3'd0, 1'b0, 1'b0);
        chk_cleared("rst_collect");

        // Reset during PRESENT drops the frame
        drive(3'd2, 1'b1, 1'b1); cyc();
        chk("rst_pre_A_valid", 32'(bus.A_valid), 32'h1);
        drive(3'd0, 1'b0, 1'b0);
        reset = 1'b1; cyc();
        reset = 1'b0;
        chk_cleared("rst_present");

        // Encoder loopback: one-code frames
        bus.A_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(enc_hi(lb_vec[i]), (lb_vec[i] != 8'h00), 1'b1);
            expect_frame(lb_exp[i], (lb_exp[i] != 8'h00) ? 4'd1 : 4'd0, 1'b0);
            cyc();
            chk("loop_A", 32'(bus.A), 32'(lb_exp[i]));
            drive(3'd0, 1'b0, 1'b0); cyc();
        end
        bus.A_ready = 1'b0;
        cyc(); cyc();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
